// File: rtl/hpu_job_ctrl.sv
// Job sequencer for the HPU datapath: latches a job configuration on start, runs item-memory
// generation, then the stream phase, and waits for the final M_AXIS beat before completing.
module hpu_job_ctrl #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned ITEM_W = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [ADDR_W-1:0] cfg_addr_j,
  input  logic [ITEM_W-1:0] cfg_item_num,
  input  logic              cfg_regen,
  input  logic              get_fin,
  input  logic              dst_valid,
  input  logic              dst_ready,
  input  logic              dst_last,
  output logic              gen,
  output logic              run,
  output logic [ITEM_W-1:0] item_a,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic [ITEM_W-1:0] item_memory_num,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_valid,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {StIdle = 2'd0, StGen = 2'd1, StRun = 2'd2, StDrain = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [ITEM_W-1:0] item_a_q, item_a_d;
  logic [ADDR_W-1:0] addr_i_q, addr_i_d;
  logic [ADDR_W-1:0] addr_j_q, addr_j_d;
  logic [ITEM_W-1:0] item_num_q, item_num_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_valid_q, mem_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_hs;

  assign last_hs = dst_valid & dst_ready & dst_last;

  always_comb begin
    state_d     = state_q;
    item_a_d    = item_a_q;
    addr_i_d    = addr_i_q;
    addr_j_d    = addr_j_q;
    item_num_d  = item_num_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    mem_valid_d = mem_valid_q;
    cnt_d       = cnt_q;

    if (busy_q && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (abort) begin
      // Abort freezes the counter at its value before the aborting cycle.
      state_d  = StIdle;
      item_a_d = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            done_d = 1'b0;
            if (cfg_item_num == '0 || cfg_addr_i == '0) begin
              err_d = 1'b1;
            end else begin
              err_d      = 1'b0;
              busy_d     = 1'b1;
              cnt_d      = '0;
              addr_i_d   = cfg_addr_i;
              addr_j_d   = cfg_addr_j;
              item_num_d = cfg_item_num;
              // Reuse the item memory only if it is complete and sized for this job.
              if (cfg_regen || !mem_valid_q || cfg_item_num != item_num_q) begin
                state_d     = StGen;
                mem_valid_d = 1'b0;
                item_a_d    = '0;
              end else begin
                state_d = StRun;
              end
            end
          end
        end
        StGen: begin
          if (item_a_q == item_num_q) begin
            state_d     = StRun;
            mem_valid_d = 1'b1;
            item_a_d    = '0;
          end else begin
            item_a_d = item_a_q + 1'b1;
          end
        end
        StRun: begin
          if (get_fin) begin
            if (last_hs) begin
              state_d = StIdle;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = StDrain;
            end
          end
        end
        StDrain: begin
          if (last_hs) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      item_a_q    <= '0;
      addr_i_q    <= '0;
      addr_j_q    <= '0;
      item_num_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      item_a_q    <= item_a_d;
      addr_i_q    <= addr_i_d;
      addr_j_q    <= addr_j_d;
      item_num_q  <= item_num_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_valid_q <= mem_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gen             = (state_q == StGen);
  assign run             = (state_q == StRun) || (state_q == StDrain);
  assign item_a          = item_a_q;
  assign addr_i          = addr_i_q;
  assign addr_j          = addr_j_q;
  assign item_memory_num = item_num_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign mem_valid       = mem_valid_q;
  assign cycle_cnt       = cnt_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_hpu_job_ctrl.sv
// Bench for hpu_job_ctrl: directed job scenarios followed by random traffic, all checked every
// cycle against a phase-level job model.
module tb_hpu_job_ctrl;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned ITEM_W = 16;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start, abort, cfg_regen, get_fin, dst_valid, dst_ready, dst_last;
  logic [ADDR_W-1:0] cfg_addr_i, cfg_addr_j;
  logic [ITEM_W-1:0] cfg_item_num;
  logic              gen, run, busy, done, err, mem_valid;
  logic [ITEM_W-1:0] item_a, item_memory_num;
  logic [ADDR_W-1:0] addr_i, addr_j;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [1:0]        state_o;

  hpu_job_ctrl #(.ADDR_W(ADDR_W), .ITEM_W(ITEM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_addr_i(cfg_addr_i),
    .cfg_addr_j(cfg_addr_j), .cfg_item_num(cfg_item_num), .cfg_regen(cfg_regen),
    .get_fin(get_fin), .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_last(dst_last),
    .gen(gen), .run(run), .item_a(item_a), .addr_i(addr_i), .addr_j(addr_j),
    .item_memory_num(item_memory_num), .busy(busy), .done(done), .err(err),
    .mem_valid(mem_valid), .cycle_cnt(cycle_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Job model: phase 0 idle, 1 generating, 2 streaming, 3 waiting for the final beat.
  int                m_phase;
  int                m_gen_done;   // generation cycles already spent in this job
  logic [ADDR_W-1:0] m_ai, m_aj;
  logic [ITEM_W-1:0] m_n;
  logic              m_busy, m_done, m_err, m_mv;
  logic [CNT_W-1:0]  m_cnt;

  task automatic m_reset();
    m_phase = 0; m_gen_done = 0; m_ai = '0; m_aj = '0; m_n = '0;
    m_busy = 0; m_done = 0; m_err = 0; m_mv = 0; m_cnt = '0;
  endtask

  task automatic m_finish();
    m_phase = 0; m_busy = 0; m_done = 1;
  endtask

  task automatic m_step();
    bit beat_end;
    beat_end = dst_valid && dst_ready && dst_last;
    if (abort) begin
      m_phase = 0; m_gen_done = 0; m_busy = 0; m_done = 0;
      return;
    end
    if (m_busy && m_cnt != '1) m_cnt = m_cnt + 1;
    if (m_phase == 0) begin
      if (start) begin
        m_done = 0;
        if (cfg_item_num == 0 || cfg_addr_i == 0) m_err = 1;
        else begin
          m_err = 0; m_busy = 1; m_cnt = '0;
          if (cfg_regen || !m_mv || cfg_item_num != m_n) begin
            m_phase = 1; m_gen_done = 0; m_mv = 0;
          end else m_phase = 2;
          m_ai = cfg_addr_i; m_aj = cfg_addr_j; m_n = cfg_item_num;
        end
      end
    end else if (m_phase == 1) begin
      m_gen_done++;
      if (m_gen_done == int'(m_n) + 1) begin
        m_phase = 2; m_gen_done = 0; m_mv = 1;
      end
    end else if (m_phase == 2) begin
      if (get_fin) begin
        if (beat_end) m_finish();
        else m_phase = 3;
      end
    end else if (beat_end) m_finish();
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    chk("gen", gen, m_phase == 1);
    chk("run", run, m_phase >= 2);
    chk("item_a", item_a, (m_phase == 1) ? m_gen_done : 0);
    chk("addr_i", addr_i, m_ai);
    chk("addr_j", addr_j, m_aj);
    chk("item_memory_num", item_memory_num, m_n);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("mem_valid", mem_valid, m_mv);
    chk("cycle_cnt", cycle_cnt, m_cnt);
    chk("state_o", state_o, m_phase);
  end

  task automatic idle_in();
    start = 0; abort = 0; get_fin = 0; dst_valid = 0; dst_ready = 0; dst_last = 0;
  endtask

  task automatic set_cfg(input int n, input int ai, input int aj, input bit regen);
    cfg_item_num = ITEM_W'(n); cfg_addr_i = ADDR_W'(ai); cfg_addr_j = ADDR_W'(aj);
    cfg_regen = regen;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    #1;
  endtask

  task automatic beat(input bit v, input bit r, input bit l);
    dst_valid = v; dst_ready = r; dst_last = l;
    tick();
    idle_in();
  endtask

  int g;

  initial begin
    idle_in();
    set_cfg(0, 0, 0, 0);
    m_reset();
    tick(); tick();
    chk("reset_state", state_o, 0);
    chk("reset_busy", busy, 0);
    rst = 0;

    // Job 1: N=4 with regeneration.
    set_cfg(4, 109, 2, 1); start = 1;
    tick(); idle_in(); set_cfg(7, 3, 3, 1);
    g = 0;
    while (gen && g < 20) begin
      chk("item_a_seq", item_a, g);
      g++;
      tick();
    end
    chk("gen_len_n4", g, 5);
    chk("run_after_gen", run, 1);
    chk("mv_after_gen", mem_valid, 1);
    get_fin = 1; tick(); idle_in();
    beat(1, 1, 0); beat(1, 0, 0); beat(1, 1, 0); beat(1, 0, 1);
    chk("drain_hold", state_o, 3);
    beat(1, 1, 1);
    chk("job1_run", run, 0);
    chk("job1_done", done, 1);
    chk("job1_cnt", cycle_cnt, 11);
    tick();
    chk("job1_cnt_hold", cycle_cnt, 11);

    // Job 2: same N, no regen, coincident get_fin and last beat.
    set_cfg(4, 109, 2, 0); start = 1;
    tick(); idle_in();
    chk("job2_run_k1", run, 1);
    chk("job2_nogen", gen, 0);
    get_fin = 1; dst_valid = 1; dst_ready = 1; dst_last = 1;
    tick(); idle_in();
    chk("job2_idle", state_o, 0);
    chk("job2_done", done, 1);

    // Job 3: N=5 forces generation; start during run is ignored.
    set_cfg(5, 9, 1, 0); start = 1;
    tick(); idle_in();
    g = 0;
    while (gen && g < 20) begin g++; tick(); end
    chk("gen_len_n5", g, 6);
    set_cfg(0, 0, 0, 1); start = 1; tick(); idle_in();
    chk("start_in_run_err", err, 0);
    chk("start_in_run_n", item_memory_num, 5);
    get_fin = 1; tick(); idle_in();
    beat(1, 1, 1);
    chk("job3_done", done, 1);

    // Rejected start, then a valid one.
    set_cfg(0, 5, 5, 0); start = 1; tick(); idle_in();
    chk("bad_err", err, 1);
    chk("bad_state", state_o, 0);
    chk("bad_run", run, 0);
    set_cfg(5, 9, 1, 0); start = 1; tick(); idle_in();
    chk("good_err", err, 0);
    chk("good_state", state_o, 2);
    get_fin = 1; dst_valid = 1; dst_ready = 1; dst_last = 1; tick(); idle_in();

    // Abort during generation.
    set_cfg(5, 9, 1, 1); start = 1; tick(); idle_in();
    tick(); tick();
    chk("abort_at", item_a, 2);
    abort = 1; tick(); idle_in();
    chk("abort_gen", gen, 0);
    chk("abort_item", item_a, 0);
    chk("abort_mv", mem_valid, 0);
    chk("abort_done", done, 0);
    set_cfg(5, 9, 1, 0); start = 1; tick(); idle_in();
    chk("regen_after_abort", gen, 1);

    // Async reset mid-drain.
    g = 0;
    while (gen && g < 20) begin g++; tick(); end
    get_fin = 1; tick(); idle_in();
    dst_valid = 1; tick();
    chk("pre_rst_drain", state_o, 3);
    #1 rst = 1;
    #1;
    chk("arst_run", run, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mv", mem_valid, 0);
    chk("arst_addr_i", addr_i, 0);
    chk("arst_cnt", cycle_cnt, 0);
    chk("arst_state", state_o, 0);
    m_reset();
    #1 rst = 0;
    idle_in();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 1023),
              $urandom_range(0, 3) == 0);
      get_fin = ($urandom_range(0, 5) == 0);
      dst_valid = $urandom_range(0, 1);
      dst_ready = $urandom_range(0, 1);
      dst_last = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle_in();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hpu_job_ctrl.md
Name: hpu_job_ctrl

Overview:
- Job sequencer for the HPU datapath; replaces the free-running run/gen register bits and the hard-wired addr_i/addr_j/item_memory_num constants.
- Takes a start command and configuration from the AXI-Lite register file.
- Runs the item-memory generation phase (gen, item_a), then the stream phase (run), and waits for the final M_AXIS beat.
- Reports busy/done/err status and a cycle count back to the register file.

Parameters:
ADDR_W, 20, width of addr_i/addr_j
ITEM_W, 16, width of item_a/item_memory_num
CNT_W, 32, width of cycle counter

Ports:
clk  in  1  AXIS clock; the only clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle job request from the register file
abort  in  1  one-cycle job cancel
cfg_addr_i  in  ADDR_W  requested addr_i
cfg_addr_j  in  ADDR_W  requested addr_j
cfg_item_num  in  ITEM_W  requested item-memory count N
cfg_regen  in  1  force regeneration of item memory
get_fin  in  1  pulse from get_ctrl: all input consumed
dst_valid  in  1  M_AXIS_TVALID
dst_ready  in  1  M_AXIS_TREADY
dst_last  in  1  M_AXIS_TLAST
gen  out  1  generation phase active
run  out  1  stream phase active
item_a  out  ITEM_W  item-memory write index
addr_i  out  ADDR_W  latched job configuration
addr_j  out  ADDR_W  latched job configuration
item_memory_num  out  ITEM_W  latched job configuration
busy  out  1  job in progress
done  out  1  sticky: last job completed
err  out  1  sticky: last start rejected
mem_valid  out  1  item memory holds a completed generation
cycle_cnt  out  CNT_W  cycles spent in the last/current job
state_o  out  2  0 IDLE, 1 GEN, 2 RUN, 3 DRAIN

Behaviour:
- Reset (async): every output 0, state IDLE.
- IDLE, start=1, abort=0:
  - Config invalid if cfg_item_num==0 or cfg_addr_i==0. If invalid: err<=1, done<=0, stay IDLE, latched config unchanged.
  - Otherwise latch the three cfg values, err<=0, done<=0, busy<=1, cycle_cnt<=0.
  - Next state is GEN if cfg_regen, or mem_valid==0, or cfg_item_num != item_memory_num (the currently latched value); else RUN.
- Latency: an accepted start at edge k makes gen or run high from cycle k+1.
- GEN:
  - gen=1; mem_valid is cleared on entry.
  - item_a=0 on the first GEN cycle and increments by 1 per cycle.
  - In the cycle item_a==item_memory_num: next state RUN, mem_valid<=1.
  - gen is high exactly N+1 cycles, with item_a covering 0..N.
  - item_a returns to 0 whenever gen=0. item_a never wraps, because N ≤ 2^ITEM_W−1 and the phase exits at N.
- RUN:
  - run=1. On get_fin go to DRAIN.
  - If get_fin and the last beat (dst_valid&dst_ready&dst_last) occur in the same cycle, go directly to IDLE with completion.
- DRAIN:
  - run stays 1.
  - On dst_valid&dst_ready&dst_last: next cycle run=0, busy=0, done=1, state IDLE.
  - While dst_valid=1 and dst_ready=0, stay in DRAIN indefinitely.
  - A dst_last beat seen in RUN before get_fin is ignored.
- Completion: gen and run are never high together. gen falls and run rises on the same edge (no gap cycle).
- abort (any state, priority over start):
  - Next cycle state IDLE; gen=run=busy=0, done=0, err unchanged.
  - Abort in GEN leaves mem_valid=0.
  - Latched config is held; cycle_cnt is frozen.
- start while busy: ignored, with no status change.
- cycle_cnt: increments every cycle busy=1 and saturates at all-ones. It holds its value in IDLE until the next accepted start.
- cfg_* inputs are sampled only at an accepted start. Later changes do not affect the running job.

Test Plan:
- rst then start with cfg N=4, addr_i=109, addr_j=2, regen=1 -> gen high 5 cycles with item_a 0,1,2,3,4; run rises on the same edge gen falls; mem_valid=1.
- Continue: get_fin pulse, then 3 beats with dst_ready toggling and the last flagged -> run drops the cycle after the handshaked last beat; done=1, busy=0; cycle_cnt equals busy-cycle count.
- Second start, same N, regen=0 -> no gen cycles; run rises at k+1. Third start with N=5 -> GEN runs 6 cycles.
- start with cfg_item_num=0 -> err=1, state stays IDLE, gen/run stay 0. Next valid start -> err=0.
- abort at item_a=2 in GEN -> next cycle gen=0, item_a=0, state IDLE, mem_valid=0, done=0. A following start with regen=0 still enters GEN.
- get_fin coincident with the last beat in RUN -> IDLE and done=1 next cycle.
- Async rst asserted mid-DRAIN between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
- start asserted during RUN -> ignored; the job finishes normally.
